fifo_rd_seq: RTL

FIFO_RD_SEQ -- requirements
Module: fifo_rd_seq

---
 rtl/fifo_rd_seq_pkg.sv | 16 +
 rtl/rd_seq_cnt.sv | 67 ++++++
 rtl/fifo_rd_seq.sv | 117 +++++++++++
 3 files changed

// File: rtl/fifo_rd_seq_pkg.sv
// Shared definitions for the FIFO read sequencer.
// Provides the default data/counter widths and the sequencer FSM state type.
package fifo_rd_seq_pkg;

  localparam int unsigned DefDataWidth = 16;
  localparam int unsigned DefCntWidth  = 8;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StRead,
    StFlush,
    StDone
  } rd_state_e;

endpackage

// File: rtl/rd_seq_cnt.sv
// Nested repeat/element/row counter chain for the FIFO read sequencer.
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   clr                 synchronous clear of all counters
//   adv                 advance the chain by one read
//   row_len, num_rows   row length and row count limits (non-zero while advancing)
//   reuse               repeats per element (already forced to >= 1)
//   rep_last            current read is the last repeat of its element
//   row_end             current read is the last repeat of the last element of a row
//   row_wrap            advancing read that completes the final row
module rd_seq_cnt import fifo_rd_seq_pkg::*; #(
  parameter int unsigned CNT_WIDTH = DefCntWidth
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 adv,
  input  logic [CNT_WIDTH-1:0] row_len,
  input  logic [CNT_WIDTH-1:0] num_rows,
  input  logic [CNT_WIDTH-1:0] reuse,
  output logic                 rep_last,
  output logic                 row_end,
  output logic                 row_wrap
);

  logic [CNT_WIDTH-1:0] rep_q, rep_d;
  logic [CNT_WIDTH-1:0] elem_q, elem_d;
  logic [CNT_WIDTH-1:0] row_q, row_d;
  logic                 elem_last, row_last;
  logic                 rep_wrap, elem_wrap;

  always_comb begin
    rep_last  = (rep_q == reuse - CNT_WIDTH'(1));
    elem_last = (elem_q == row_len - CNT_WIDTH'(1));
    row_last  = (row_q == num_rows - CNT_WIDTH'(1));
    rep_wrap  = adv & rep_last;
    elem_wrap = rep_wrap & elem_last;
    row_wrap  = elem_wrap & row_last;
    row_end   = rep_last & elem_last;

    rep_d  = rep_q;
    elem_d = elem_q;
    row_d  = row_q;
    if (clr) begin
      rep_d  = '0;
      elem_d = '0;
      row_d  = '0;
    end else begin
      if (adv) rep_d = rep_last ? '0 : rep_q + CNT_WIDTH'(1);
      if (rep_wrap) elem_d = elem_last ? '0 : elem_q + CNT_WIDTH'(1);
      if (elem_wrap) row_d = row_last ? '0 : row_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rep_q  <= '0;
      elem_q <= '0;
      row_q  <= '0;
    end else begin
      rep_q  <= rep_d;
      elem_q <= elem_d;
      row_q  <= row_d;
    end
  end

endmodule

// File: rtl/fifo_rd_seq.sv
// FIFO read sequencer: reads row_len*num_rows elements, each repeated `reuse`
// times, pausing on stall, and forwards the returned words with row markers.
// Ports:
//   clk, rst_n                      clock and synchronous active-low reset
//   start, row_len, num_rows, reuse launch pulse and sequence configuration
//   stall                           consumer hold request
//   fifo_rd_clr/en/inc, fifo_data   FIFO read interface (data one cycle after en)
//   out_data/valid/row_last         forwarded stream
//   busy, done                      sequence status and completion pulse
module fifo_rd_seq import fifo_rd_seq_pkg::*; #(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned CNT_WIDTH  = DefCntWidth
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  row_len,
  input  logic [CNT_WIDTH-1:0]  num_rows,
  input  logic [CNT_WIDTH-1:0]  reuse,
  input  logic                  stall,
  output logic                  fifo_rd_clr,
  output logic                  fifo_rd_en,
  output logic                  fifo_rd_inc,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_row_last,
  output logic                  busy,
  output logic                  done
);

  rd_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0] row_len_q, num_rows_q, reuse_q;
  logic                 latch_cfg, cnt_clr, cnt_adv;
  logic                 rep_last, row_end, row_wrap;
  logic                 out_valid_q, row_last_q;

  rd_seq_cnt #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .adv      (cnt_adv),
    .row_len  (row_len_q),
    .num_rows (num_rows_q),
    .reuse    (reuse_q),
    .rep_last (rep_last),
    .row_end  (row_end),
    .row_wrap (row_wrap)
  );

  always_comb begin
    state_d     = state_q;
    latch_cfg   = 1'b0;
    cnt_clr     = 1'b0;
    cnt_adv     = 1'b0;
    fifo_rd_clr = 1'b0;
    fifo_rd_en  = 1'b0;
    fifo_rd_inc = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          latch_cfg = 1'b1;
          state_d   = StClr;
        end
      end
      StClr: begin
        fifo_rd_clr = 1'b1;
        cnt_clr     = 1'b1;
        state_d     = (row_len_q == '0 || num_rows_q == '0) ? StFlush : StRead;
      end
      StRead: begin
        if (!stall) begin
          fifo_rd_en  = 1'b1;
          fifo_rd_inc = rep_last;
          cnt_adv     = 1'b1;
          if (row_wrap) state_d = StFlush;
        end
      end
      StFlush: state_d = StDone;
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      row_len_q   <= '0;
      num_rows_q  <= '0;
      reuse_q     <= '0;
      out_valid_q <= 1'b0;
      row_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      if (latch_cfg) begin
        row_len_q  <= row_len;
        num_rows_q <= num_rows;
        // A reuse of 0 behaves as a single read per element.
        reuse_q    <= (reuse == '0) ? CNT_WIDTH'(1) : reuse;
      end
      out_valid_q <= fifo_rd_en;
      row_last_q  <= fifo_rd_en & row_end;
    end
  end

  assign busy         = (state_q != StIdle);
  assign out_valid    = out_valid_q;
  assign out_data     = out_valid_q ? fifo_data : '0;
  assign out_row_last = row_last_q & out_valid_q;

endmodule
